forward_ctrl_unit: RTL and testbench
====================================

Name: forward_ctrl_unit

Overview:
- Producer of the select lines consumed by the datapath operand muxes (2-input and 3-input select encodings).
- Tracks destination-register state for the EX, MEM and WB stages of the RV32IM pipeline.
- Drives registered forwarding selects for the instruction entering EX, and a load-use STALL.
- Sits beside the ID/EX pipeline register and is clocked with it.

Parameters:
- REG_ADDR_W, 5, register-address width.
- DIV_LATENCY, 8, extra EX cycles for DIV/DIVU/REM/REMU; used only with the optional feature; legal range 1..15.

Ports:
- CLK  input  1  pipeline clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- ID_VALID  input  1  ID holds a real instruction.
- ID_RS1  input  REG_ADDR_W  source register 1 of the ID instruction.
- ID_RS2  input  REG_ADDR_W  source register 2 of the ID instruction.
- ID_RS1_USED  input  1  ID instruction reads rs1.
- ID_RS2_USED  input  1  ID instruction reads rs2.
- ID_RD  input  REG_ADDR_W  destination register of the ID instruction.
- ID_REG_WRITE  input  1  ID instruction writes rd.
- ID_MEM_READ  input  1  ID instruction is a load.
- ID_IS_DIV  input  1  ID instruction is a divide/remainder.
- FLUSH  input  1  branch/jump taken in EX; kill the ID instruction.
- FWD_A_SEL  output  2  EX operand-A mux select, registered.
- FWD_B_SEL  output  2  EX operand-B mux select, registered.
- STALL  output  1  hold PC and IF/ID, bubble into EX; combinational.

Behaviour:
- Select encoding, both outputs:
  - 00 = register-file value.
  - 01 = MEM-stage ALU result.
  - 10 = WB-stage writeback value.
  - 11 = never driven; asserting it is a bench error.
- Internal shadow per stage (EX, MEM, WB): valid, rd, reg_write, mem_read. A stage is "writing r" iff valid & reg_write & rd==r & r!=0.
- Reset: all shadow valids = 0, FWD_A_SEL = FWD_B_SEL = 00, STALL = 0, divide counter = 0. Reset wins over every other input.
- Load-use hazard (combinational): STALL = ID_VALID & EX.valid & EX.mem_read & EX.rd!=0 & ((ID_RS1_USED & ID_RS1==EX.rd) | (ID_RS2_USED & ID_RS2==EX.rd)) & !FLUSH.
- Each rising edge, when not in reset:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields with valid = ID_VALID & !STALL & !FLUSH. Stall and flush both insert a bubble.
- Select for source s (rs1→A, rs2→B) on the same edge, for the instruction entering EX:
  - s unused, s==0, or an inserted bubble → 00.
  - Else if current EX is writing s → 01 (the producer moves to MEM).
  - Else if current MEM is writing s → 10 (the producer moves to WB).
  - Else → 00.
  - Newer producer has priority over older.
- Current WB results need no forwarding; the register file writes first half-cycle.
- Latency:
  - Selects are valid one cycle after the ID inputs are sampled, aligned with the instruction in EX.
  - STALL is the same cycle as the inputs.
- FLUSH and STALL together: FLUSH wins, STALL = 0, EX gets a bubble.
- Back-to-back stalls: the hazard clears after one bubble, because the load advances to MEM. The next edge yields select 10.
- RESET asserted mid-stall: STALL drops in the reset cycle; all shadows are cleared.

Optional Feature:
- Macro FWD_CTRL_MULDIV_STALL_EN.
- When defined:
  - When an instruction with ID_IS_DIV enters EX (not bubbled), a 4-bit counter loads DIV_LATENCY.
  - While counter != 0: STALL = 1, EX/MEM/WB shadows hold (no shift), selects hold, and the counter decrements each edge.
  - At counter == 0, normal shifting resumes.
  - FLUSH clears the counter.
  - Load-use STALL ORs with the divide stall.
- When undefined:
  - ID_IS_DIV is ignored; divide is treated as single-cycle.
  - The counter is absent.

Test Plan:
1. ADD x5 then SUB x6,x5,x7 back-to-back → cycle with SUB in EX: FWD_A_SEL=01, FWD_B_SEL=00, STALL never 1.
2. ADD x5; NOP; OR x8,x9,x5 → OR in EX: FWD_B_SEL=10, FWD_A_SEL=00.
3. LW x5 then ADD x6,x5,x5 → STALL=1 exactly one cycle, EX bubble; next cycle ADD in EX with FWD_A_SEL=FWD_B_SEL=10.
4. ADDI x0,x0,1 then ADD x1,x0,x0 → selects 00 (x0 never forwarded); ADD x5 twice then use x5 → select 01 (newest wins).
5. LW x5 in EX, ID reads x5, FLUSH=1 same cycle → STALL=0; EX valid=0 next cycle; selects 00.
6. With FWD_CTRL_MULDIV_STALL_EN, DIV_LATENCY=8: DIV x3 then ADD x4,x3,x1 → STALL high 8 cycles; ADD enters EX with FWD_A_SEL=01. RESET during the 4th stall cycle → STALL=0 next cycle, selects 00.

Source files
------------

// File: rtl/forward_ctrl_unit.sv
// Forwarding-select and load-use stall generator for the EX operand muxes of the RV32IM pipeline.
// Optional multi-cycle divide stall is enabled by defining FWD_CTRL_MULDIV_STALL_EN.
module forward_ctrl_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int DIV_LATENCY = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ID_VALID,
    input  logic [REG_ADDR_W-1:0] ID_RS1,
    input  logic [REG_ADDR_W-1:0] ID_RS2,
    input  logic                  ID_RS1_USED,
    input  logic                  ID_RS2_USED,
    input  logic [REG_ADDR_W-1:0] ID_RD,
    input  logic                  ID_REG_WRITE,
    input  logic                  ID_MEM_READ,
    input  logic                  ID_IS_DIV,
    input  logic                  FLUSH,
    output logic [1:0]            FWD_A_SEL,
    output logic [1:0]            FWD_B_SEL,
    output logic                  STALL
);

    typedef logic [REG_ADDR_W-1:0] reg_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // WB is not shadowed: the register file writes in the first half-cycle,
    // so a producer that has reached WB never needs a forwarding path.
    logic       ex_vld_q, ex_wr_q, ex_mrd_q;
    reg_t       ex_rd_q;
    logic       mem_vld_q, mem_wr_q;
    reg_t       mem_rd_q;
    logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

    logic load_use;
    logic div_busy;
    logic hold;
    logic enter_vld;

    function automatic logic [1:0] pick_sel(input logic used, input reg_t src,
                                            input logic ex_hit, input logic mem_hit);
        logic [1:0] sel;
        sel = SEL_RF;
        if (used && src != '0) begin
            if (ex_hit)       sel = SEL_MEM;
            else if (mem_hit) sel = SEL_WB;
        end
        return sel;
    endfunction

    assign load_use = ID_VALID & ex_vld_q & ex_mrd_q & (ex_rd_q != '0) &
                      ((ID_RS1_USED & (ID_RS1 == ex_rd_q)) |
                       (ID_RS2_USED & (ID_RS2 == ex_rd_q)));

`ifdef FWD_CTRL_MULDIV_STALL_EN
    logic [3:0] div_cnt_q, div_cnt_d;

    assign div_busy = (div_cnt_q != 4'd0);
    assign hold     = div_busy & ~FLUSH;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (FLUSH)
            div_cnt_d = 4'd0;
        else if (div_busy)
            div_cnt_d = div_cnt_q - 4'd1;
        else if (enter_vld && ID_IS_DIV)
            div_cnt_d = 4'(DIV_LATENCY);
    end

    always_ff @(posedge CLK) begin
        if (RESET) div_cnt_q <= 4'd0;
        else       div_cnt_q <= div_cnt_d;
    end
`else
    logic unused_div;

    assign div_busy   = 1'b0;
    assign hold       = 1'b0;
    assign unused_div = ID_IS_DIV | (DIV_LATENCY == 0);
`endif

    // Flush beats any stall; reset forces the stall low in its own cycle.
    assign STALL     = (load_use | div_busy) & ~FLUSH & ~RESET;
    assign enter_vld = ID_VALID & ~STALL & ~FLUSH;

    always_comb begin
        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
        if (enter_vld) begin
            fwd_a_d = pick_sel(ID_RS1_USED, ID_RS1,
                               ex_vld_q & ex_wr_q & (ex_rd_q == ID_RS1),
                               mem_vld_q & mem_wr_q & (mem_rd_q == ID_RS1));
            fwd_b_d = pick_sel(ID_RS2_USED, ID_RS2,
                               ex_vld_q & ex_wr_q & (ex_rd_q == ID_RS2),
                               mem_vld_q & mem_wr_q & (mem_rd_q == ID_RS2));
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_vld_q  <= 1'b0;
            ex_wr_q   <= 1'b0;
            ex_mrd_q  <= 1'b0;
            ex_rd_q   <= '0;
            mem_vld_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_rd_q  <= '0;
            fwd_a_q   <= SEL_RF;
            fwd_b_q   <= SEL_RF;
        end else if (!hold) begin
            mem_vld_q <= ex_vld_q;
            mem_wr_q  <= ex_wr_q;
            mem_rd_q  <= ex_rd_q;
            ex_vld_q  <= enter_vld;
            ex_wr_q   <= ID_REG_WRITE;
            ex_mrd_q  <= ID_MEM_READ;
            ex_rd_q   <= ID_RD;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
        end
    end

    assign FWD_A_SEL = fwd_a_q;
    assign FWD_B_SEL = fwd_b_q;

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// Scoreboard bench for forward_ctrl_unit: expected selects are queued as each ID instruction is driven.
module tb_forward_ctrl_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ID_VALID;
    logic [4:0] ID_RS1, ID_RS2, ID_RD;
    logic       ID_RS1_USED, ID_RS2_USED;
    logic       ID_REG_WRITE, ID_MEM_READ, ID_IS_DIV, FLUSH;
    logic [1:0] FWD_A_SEL, FWD_B_SEL;
    logic       STALL;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];

    forward_ctrl_unit #(.REG_ADDR_W(5), .DIV_LATENCY(8)) dut (
        .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
        .ID_RD(ID_RD), .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ),
        .ID_IS_DIV(ID_IS_DIV), .FLUSH(FLUSH),
        .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL), .STALL(STALL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pipeline cycle: drive ID at negedge, check STALL, then check selects after the edge.
    task automatic cyc(input string tag, input logic rst, input logic v,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic mrd, input logic dv, input logic fl,
                       input logic es, input logic [1:0] ea, input logic [1:0] eb);
        logic [3:0] e;
        @(negedge CLK);
        RESET = rst; ID_VALID = v; ID_RS1 = rs1; ID_RS2 = rs2;
        ID_RS1_USED = u1; ID_RS2_USED = u2; ID_RD = rd;
        ID_REG_WRITE = wr; ID_MEM_READ = mrd; ID_IS_DIV = dv; FLUSH = fl;
        #1;
        chk({tag, ".stall"}, 32'(STALL), 32'(es));
        exp_q.push_back({ea, eb});
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".a"}, 32'(FWD_A_SEL), 32'(e[3:2]));
            chk({tag, ".b"}, 32'(FWD_B_SEL), 32'(e[1:0]));
        end
    endtask

    task automatic nop(input string tag);
        cyc(tag, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 2'b00, 2'b00);
    endtask

    initial begin
        RESET = 1'b1; ID_VALID = 1'b0; ID_RS1 = 5'd0; ID_RS2 = 5'd0; ID_RD = 5'd0;
        ID_RS1_USED = 1'b0; ID_RS2_USED = 1'b0; ID_REG_WRITE = 1'b0;
        ID_MEM_READ = 1'b0; ID_IS_DIV = 1'b0; FLUSH = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.a", 32'(FWD_A_SEL), 32'd0);
        chk("rst.b", 32'(FWD_B_SEL), 32'd0);
        chk("rst.stall", 32'(STALL), 32'd0);

        //          tag        rst   v     rs1    rs2    u1    u2    rd     wr    mrd   dv    fl    stall a      b
        // ADD x5,x1,x2 ; SUB x6,x5,x7
        cyc("t1.add", 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("t1.sub", 1'b0, 1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        nop("t1.n0"); nop("t1.n1");

        // ADD x5 ; NOP ; OR x8,x9,x5
        cyc("t2.add", 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop("t2.gap");
        cyc("t2.or",  1'b0, 1'b1, 5'd9, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
        nop("t2.n0"); nop("t2.n1");

        // LW x5,0(x1) ; ADD x6,x5,x5 stalls once then forwards from WB
        cyc("t3.lw",   1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("t3.stl",  1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cyc("t3.add",  1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
        nop("t3.n0"); nop("t3.n1");

        // Unused source matching a load destination: no stall, no forward
        cyc("u.lw",   1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("u.addi", 1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop("u.n0"); nop("u.n1");

        // x0 is never forwarded or stalled on; newest producer wins
        cyc("t4.addi", 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("t4.x0",   1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop("t4.n0");
        cyc("t4.p0",   1'b0, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("t4.p1",   1'b0, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("t4.new",  1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
        nop("t4.n1"); nop("t4.n2");
        cyc("t4.lw0",  1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("t4.use0", 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop("t4.n3"); nop("t4.n4");

        // Flush beats load-use; flushed load must not reach EX
        cyc("t5.lw",   1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("t5.fl",   1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        cyc("t5.use",  1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        nop("t5.n0"); nop("t5.n1");

        // Reset in the middle of a load-use stall clears every shadow
        cyc("r.lw",   1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("r.stl",  1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cyc("r.rst",  1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("r.post", 1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop("r.n0"); nop("r.n1");

`ifdef FWD_CTRL_MULDIV_STALL_EN
        // DIV x3 ; ADD x4,x3,x1 waits out the divide then forwards from MEM
        cyc("t6.div", 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 8; i++)
            cyc("t6.busy", 1'b0, 1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cyc("t6.add", 1'b0, 1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        nop("t6.n0"); nop("t6.n1");
        cyc("t6.div2", 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++)
            cyc("t6.busy2", 1'b0, 1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cyc("t6.rst",  1'b1, 1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("t6.post", 1'b0, 1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
`endif

        chk("end.queue", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
